// File: rtl/aes_round_sequencer_if.sv
// Handshake/status bundle between the AES round sequencer and its requesters/datapath.
// The optional err line exists only when AES_SEQ_ERR_EN is defined.
interface aes_round_sequencer_if #(
  parameter int IDXW = 4
);
  logic            enc_req;
  logic [1:0]      enc_ks;
  logic            dec_req;
  logic [1:0]      dec_ks;
  logic            done_ack;
  logic            enc_gnt;
  logic            dec_gnt;
  logic            load;
  logic [1:0]      round_type;
  logic [IDXW-1:0] round_idx;
  logic            dir;
  logic [IDXW-1:0] nr_cur;
  logic            busy;
  logic            done;
`ifdef AES_SEQ_ERR_EN
  logic            err;
`endif

  modport master (
    output enc_req, enc_ks, dec_req, dec_ks, done_ack,
    input  enc_gnt, dec_gnt, load, round_type, round_idx, dir, nr_cur, busy, done
`ifdef AES_SEQ_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  enc_req, enc_ks, dec_req, dec_ks, done_ack,
    output enc_gnt, dec_gnt, load, round_type, round_idx, dir, nr_cur, busy, done
`ifdef AES_SEQ_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller arbitrating one round datapath between encrypt and decrypt requesters.
// Optional feature macro: AES_SEQ_ERR_EN (flags ks=11 requests with err instead of running them).
module aes_round_sequencer #(
  parameter int IDXW   = 4,
  parameter int NR_128 = 10,
  parameter int NR_192 = 12,
  parameter int NR_256 = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_round_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] RT_NONE  = 2'b00;
  localparam logic [1:0] RT_INIT  = 2'b01;
  localparam logic [1:0] RT_MID   = 2'b10;
  localparam logic [1:0] RT_FINAL = 2'b11;

  localparam logic [IDXW-1:0] NR128 = IDXW'(NR_128);
  localparam logic [IDXW-1:0] NR192 = IDXW'(NR_192);
  localparam logic [IDXW-1:0] NR256 = IDXW'(NR_256);
  localparam logic [IDXW-1:0] ONE   = IDXW'(1);

  function automatic logic [IDXW-1:0] nr_decode(input logic [1:0] ks);
    logic [IDXW-1:0] nr;
    case (ks)
      2'b00:   nr = NR128;
      2'b01:   nr = NR192;
      default: nr = NR256;
    endcase
    return nr;
  endfunction

  state_t          state_q, state_d;
  logic            enc_gnt_q, enc_gnt_d;
  logic            dec_gnt_q, dec_gnt_d;
  logic            load_q, load_d;
  logic [1:0]      round_type_q, round_type_d;
  logic [IDXW-1:0] round_idx_q, round_idx_d;
  logic            dir_q, dir_d;
  logic [IDXW-1:0] nr_cur_q, nr_cur_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  // Round-robin pointer: 1 means decrypt was served last, so encrypt wins a tie.
  logic            last_dec_q, last_dec_d;
`ifdef AES_SEQ_ERR_EN
  logic            err_q, err_d;
`endif

  logic            any_req;
  logic            pick_dec;
  logic [1:0]      sel_ks;
  logic [IDXW-1:0] sel_nr;
  logic            last_round;
  logic            sel_illegal;

  always_comb begin
    any_req     = bus.enc_req | bus.dec_req;
    pick_dec    = bus.dec_req & (~bus.enc_req | ~last_dec_q);
    sel_ks      = pick_dec ? bus.dec_ks : bus.enc_ks;
    sel_nr      = nr_decode(sel_ks);
    last_round  = dir_q ? (round_idx_q == ONE) : (round_idx_q == (nr_cur_q - ONE));
`ifdef AES_SEQ_ERR_EN
    sel_illegal = (sel_ks == 2'b11);
`else
    sel_illegal = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = sel_illegal ? S_DONE : S_INIT;
        end
      end
      S_INIT:  state_d = S_ROUND;
      S_ROUND: begin
        if (last_round) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: state_d = S_DONE;
      S_DONE: begin
        if (bus.done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: every output is the registered image of what the next state requires.
  always_comb begin
    enc_gnt_d    = 1'b0;
    dec_gnt_d    = 1'b0;
    load_d       = 1'b0;
    round_type_d = RT_NONE;
    round_idx_d  = round_idx_q;
    dir_d        = dir_q;
    nr_cur_d     = nr_cur_q;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    last_dec_d   = last_dec_q;
`ifdef AES_SEQ_ERR_EN
    err_d        = err_q;
`endif
    case (state_d)
      S_INIT: begin
        enc_gnt_d    = ~pick_dec;
        dec_gnt_d    = pick_dec;
        load_d       = 1'b1;
        round_type_d = RT_INIT;
        dir_d        = pick_dec;
        nr_cur_d     = sel_nr;
        last_dec_d   = pick_dec;
        round_idx_d  = pick_dec ? sel_nr : '0;
      end
      S_ROUND: begin
        round_type_d = RT_MID;
        if (state_q == S_INIT) begin
          round_idx_d = dir_q ? (nr_cur_q - ONE) : ONE;
        end else begin
          round_idx_d = dir_q ? (round_idx_q - ONE) : (round_idx_q + ONE);
        end
      end
      S_FINAL: begin
        round_type_d = RT_FINAL;
        round_idx_d  = dir_q ? '0 : nr_cur_q;
      end
      S_DONE: begin
`ifdef AES_SEQ_ERR_EN
        // Illegal key size jumps straight here from IDLE: grant it, flag it, skip the datapath.
        if (state_q == S_IDLE) begin
          enc_gnt_d  = ~pick_dec;
          dec_gnt_d  = pick_dec;
          dir_d      = pick_dec;
          nr_cur_d   = sel_nr;
          last_dec_d = pick_dec;
          err_d      = 1'b1;
        end
`endif
      end
      default: begin
`ifdef AES_SEQ_ERR_EN
        err_d = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_gnt_q    <= 1'b0;
      dec_gnt_q    <= 1'b0;
      load_q       <= 1'b0;
      round_type_q <= RT_NONE;
      round_idx_q  <= '0;
      dir_q        <= 1'b0;
      nr_cur_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      last_dec_q   <= 1'b1;
`ifdef AES_SEQ_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      enc_gnt_q    <= enc_gnt_d;
      dec_gnt_q    <= dec_gnt_d;
      load_q       <= load_d;
      round_type_q <= round_type_d;
      round_idx_q  <= round_idx_d;
      dir_q        <= dir_d;
      nr_cur_q     <= nr_cur_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      last_dec_q   <= last_dec_d;
`ifdef AES_SEQ_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.enc_gnt    = enc_gnt_q;
  assign bus.dec_gnt    = dec_gnt_q;
  assign bus.load       = load_q;
  assign bus.round_type = round_type_q;
  assign bus.round_idx  = round_idx_q;
  assign bus.dir        = dir_q;
  assign bus.nr_cur     = nr_cur_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef AES_SEQ_ERR_EN
  assign bus.err        = err_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: table-driven operations with a per-cycle
// expected-output scoreboard, plus hand sequences for held done, arbitration and mid-run reset.
module tb_aes_round_sequencer;

  logic clk;
  logic reset;

  aes_round_sequencer_if #(.IDXW(4)) bus();

  aes_round_sequencer #(.IDXW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       eg;
    logic       dg;
    logic       ld;
    logic [1:0] rt;
    logic [3:0] idx;
    logic       dn;
    logic       bsy;
    logic       dr;
    logic [3:0] nr;
  } obs_t;

  typedef struct {
    bit       is_dec;
    bit [1:0] ks;
    int       nr;
  } vec_t;

  obs_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.eg  = bus.enc_gnt;
    o.dg  = bus.dec_gnt;
    o.ld  = bus.load;
    o.rt  = bus.round_type;
    o.idx = bus.round_idx;
    o.dn  = bus.done;
    o.bsy = bus.busy;
    o.dr  = bus.dir;
    o.nr  = bus.nr_cur;
    return o;
  endfunction

  // Waits (bounded) for a grant, then checks every cycle from INIT through the first DONE cycle.
  task automatic expect_op(input bit is_dec, input int nr, output int waited);
    bit   found;
    obs_t e;
    obs_t a;
    found  = 1'b0;
    waited = 0;
    for (int w = 1; w <= 40 && !found; w++) begin
      @(negedge clk);
      if (bus.enc_gnt || bus.dec_gnt) begin
        found  = 1'b1;
        waited = w;
      end
    end
    chk("grant_seen", {31'd0, found}, 32'd1);
    if (!found) return;
    if (is_dec) bus.dec_req = 1'b0;
    else        bus.enc_req = 1'b0;
`ifdef AES_SEQ_ERR_EN
    if (nr == 0) begin
      chk("err_grant", {28'd0, bus.enc_gnt | bus.dec_gnt, bus.done, bus.err, bus.load}, 32'hE);
      chk("err_dir", {31'd0, bus.dir}, {31'd0, is_dec});
      $display("op dir=%0d illegal ks -> err waited=%0d", is_dec, waited);
      return;
    end
`endif
    for (int c = 1; c <= nr + 2; c++) begin
      e.eg  = (c == 1) && !is_dec;
      e.dg  = (c == 1) && is_dec;
      e.ld  = (c == 1);
      e.rt  = (c == 1) ? 2'b01 : (c <= nr) ? 2'b10 : (c == nr + 1) ? 2'b11 : 2'b00;
      if (c == 1)        e.idx = is_dec ? 4'(nr) : 4'd0;
      else if (c <= nr)  e.idx = is_dec ? 4'(nr - (c - 1)) : 4'(c - 1);
      else               e.idx = is_dec ? 4'd0 : 4'(nr);
      e.dn  = (c == nr + 2);
      e.bsy = 1'b1;
      e.dr  = is_dec;
      e.nr  = 4'(nr);
      sb_q.push_back(e);
    end
    for (int c = 1; sb_q.size() > 0; c++) begin
      if (c > 1) @(negedge clk);
      e = sb_q.pop_front();
      a = observe();
      if (a !== e) begin
        total++;
        bad++;
        $display("FAIL cycle%0d dir=%0d nr=%0d: got %h want %h", c, is_dec, nr, a, e);
      end else begin
        total++;
      end
    end
    $display("op dir=%0d nr=%0d waited=%0d done after %0d cycles", is_dec, nr, waited, nr + 2);
  endtask

  task automatic do_ack();
    bus.done_ack = 1'b1;
    @(negedge clk);
    bus.done_ack = 1'b0;
    chk("ack_done_clr", {31'd0, bus.done}, 32'd0);
    chk("ack_busy_clr", {31'd0, bus.busy}, 32'd0);
`ifdef AES_SEQ_ERR_EN
    chk("ack_err_clr", {31'd0, bus.err}, 32'd0);
`endif
  endtask

  task automatic drive_req(input bit is_dec, input bit [1:0] ks);
    if (is_dec) begin
      bus.dec_ks  = ks;
      bus.dec_req = 1'b1;
    end else begin
      bus.enc_ks  = ks;
      bus.enc_req = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   w;
    bit   hit;

    vecs[0] = '{1'b0, 2'b00, 10};
    vecs[1] = '{1'b1, 2'b10, 14};
    vecs[2] = '{1'b0, 2'b01, 12};
    vecs[3] = '{1'b1, 2'b00, 10};
`ifdef AES_SEQ_ERR_EN
    vecs[4] = '{1'b0, 2'b11, 0};
`else
    vecs[4] = '{1'b0, 2'b11, 14};
`endif
    vecs[5] = '{1'b1, 2'b01, 12};

    reset        = 1'b1;
    bus.enc_req  = 1'b0;
    bus.enc_ks   = 2'b00;
    bus.dec_req  = 1'b0;
    bus.dec_ks   = 2'b00;
    bus.done_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {16'd0, observe()}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {16'd0, observe()}, 32'd0);

    // done_ack outside DONE must do nothing
    bus.done_ack = 1'b1;
    @(negedge clk);
    bus.done_ack = 1'b0;
    chk("stray_ack", {16'd0, observe()}, 32'd0);

    // 128-bit encrypt, then done held without ack while decrypt waits
    drive_req(1'b0, 2'b00);
    expect_op(1'b0, 10, w);
    chk("enc128_wait", w, 1);
    drive_req(1'b1, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("done_held", {31'd0, bus.done}, 32'd1);
      chk("no_gnt_busy", {30'd0, bus.enc_gnt, bus.dec_gnt}, 32'd0);
    end
    bus.done_ack = 1'b1;
    @(negedge clk);
    bus.done_ack = 1'b0;
    chk("ack_idle_done", {31'd0, bus.done}, 32'd0);
    chk("ack_idle_gnt", {31'd0, bus.dec_gnt}, 32'd0);
    expect_op(1'b1, 14, w);
    chk("dec256_wait", w, 1);
    do_ack();

    for (int v = 0; v < 6; v++) begin
      drive_req(vecs[v].is_dec, vecs[v].ks);
      expect_op(vecs[v].is_dec, vecs[v].nr, w);
      chk("vec_wait", w, 1);
      do_ack();
    end

    // Both requesters held: encrypt first after reset, then alternate
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_req(1'b0, 2'b00);
    drive_req(1'b1, 2'b00);
    expect_op(1'b0, 10, w);
    chk("rr1_wait", w, 1);
    bus.enc_req = 1'b1;
    do_ack();
    expect_op(1'b1, 10, w);
    chk("rr2_wait", w, 1);
    bus.dec_req = 1'b1;
    do_ack();
    expect_op(1'b0, 10, w);
    chk("rr3_wait", w, 1);
    bus.dec_req = 1'b0;
    do_ack();

    // Reset in the middle of a 192-bit encrypt
    drive_req(1'b0, 2'b01);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (bus.enc_gnt) bus.enc_req = 1'b0;
      if (bus.round_type == 2'b10 && bus.round_idx == 4'd5) hit = 1'b1;
    end
    chk("reach_idx5", {31'd0, hit}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {16'd0, observe()}, 32'd0);
    @(negedge clk);
    chk("reset_no_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    drive_req(1'b0, 2'b01);
    expect_op(1'b0, 12, w);
    chk("restart_wait", w, 1);
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
